// File: rtl/stft_sample_feeder.sv
// stft_sample_feeder: buffers front-end samples, keeps the FFT_SIZE-deep history and paces start_compute to the STFT sweep.
// Build option STFT_FEEDER_WARMUP_EN: pulse from the first sample, with oldest_sample_out masked to 0 during warm-up.
module stft_sample_feeder #(
  parameter int unsigned WORD_WIDTH = 16,
  parameter int unsigned FFT_SIZE   = 256,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WORD_WIDTH-1:0]       in_sample,
  input  logic                        compute_busy,
  output logic                        start_compute,
  output logic [WORD_WIDTH-1:0]       sample_out,
  output logic [WORD_WIDTH-1:0]       oldest_sample_out,
  output logic [$clog2(FFT_SIZE)-1:0] wr_ptr,
  output logic                        overrun,
  input  logic                        clear_overrun
);

  localparam int unsigned ADDR_W = $clog2(FFT_SIZE);
  localparam int unsigned FILL_W = ADDR_W + 1;
  localparam int unsigned FPTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned FCNT_W = FPTR_W + 1;

  typedef enum logic [2:0] {S_IDLE, S_READ, S_ISSUE, S_HOLD, S_WAIT} state_e;

  state_e state_q, state_d;

  logic [WORD_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [FPTR_W-1:0]     fifo_rd_q, fifo_rd_d, fifo_wr_q, fifo_wr_d;
  logic [FCNT_W-1:0]     fifo_cnt_q, fifo_cnt_d;
  logic                  in_ready_q, in_ready_d;
  logic                  push, pop;

  logic [WORD_WIDTH-1:0] ram [FFT_SIZE];
  logic [WORD_WIDTH-1:0] ram_rdata_q;
  logic                  ram_we;

  logic [WORD_WIDTH-1:0] sample_q, sample_d, sample_out_q, sample_out_d;
  logic [WORD_WIDTH-1:0] oldest_q, oldest_d, oldest_masked;
  logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [FILL_W-1:0]     fill_q, fill_d;
  logic                  hist_full, pulse_en, latch_out;
  logic                  start_q, start_d, overrun_q, overrun_d;

  assign in_ready          = in_ready_q;
  assign start_compute     = start_q;
  assign sample_out        = sample_out_q;
  assign oldest_sample_out = oldest_q;
  assign wr_ptr            = wr_ptr_q;
  assign overrun           = overrun_q;

  // Input FIFO pointers and occupancy; in_ready is the registered not-full of the next count.
  assign push = in_valid && in_ready_q;

  always_comb begin
    fifo_wr_d  = fifo_wr_q;
    fifo_rd_d  = fifo_rd_q;
    fifo_cnt_d = fifo_cnt_q;
    if (push) fifo_wr_d = fifo_wr_q + FPTR_W'(1);
    if (pop)  fifo_rd_d = fifo_rd_q + FPTR_W'(1);
    if (push && !pop)      fifo_cnt_d = fifo_cnt_q + FCNT_W'(1);
    else if (pop && !push) fifo_cnt_d = fifo_cnt_q - FCNT_W'(1);
    in_ready_d = (fifo_cnt_d != FCNT_W'(FIFO_DEPTH));
  end

  assign hist_full = (fill_q == FILL_W'(FFT_SIZE));

`ifdef STFT_FEEDER_WARMUP_EN
  assign pulse_en      = 1'b1;
  assign oldest_masked = hist_full ? ram_rdata_q : '0;
`else
  assign pulse_en      = hist_full;
  assign oldest_masked = ram_rdata_q;
`endif

  // Sequencer: pop, read the departing sample, issue, then wait out the STFT sweep.
  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    latch_out = 1'b0;
    ram_we    = 1'b0;
    start_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fifo_cnt_q != FCNT_W'(0)) begin
          pop     = 1'b1;
          state_d = S_READ;
        end
      end
      S_READ: begin
        latch_out = 1'b1;
        start_d   = pulse_en;
        state_d   = S_ISSUE;
      end
      S_ISSUE: begin
        ram_we  = 1'b1;
        state_d = S_HOLD;
      end
      S_HOLD:  state_d = S_WAIT;
      S_WAIT: begin
        if (!compute_busy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sample_d     = pop ? fifo_mem[fifo_rd_q] : sample_q;
    sample_out_d = latch_out ? sample_q : sample_out_q;
    oldest_d     = latch_out ? oldest_masked : oldest_q;
    wr_ptr_d     = ram_we ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    fill_d       = (ram_we && !hist_full) ? fill_q + FILL_W'(1) : fill_q;
    overrun_d    = (in_valid && !in_ready_q) ? 1'b1 : (clear_overrun ? 1'b0 : overrun_q);
  end

  // Storage arrays carry no reset; validity comes from the FIFO count and fill_q.
  always_ff @(posedge clk) begin
    if (push)   fifo_mem[fifo_wr_q] <= in_sample;
    if (ram_we) ram[wr_ptr_q]       <= sample_q;
    if (pop)    ram_rdata_q         <= ram[wr_ptr_q];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      fifo_rd_q    <= '0;
      fifo_wr_q    <= '0;
      fifo_cnt_q   <= '0;
      in_ready_q   <= 1'b1;
      sample_q     <= '0;
      sample_out_q <= '0;
      oldest_q     <= '0;
      wr_ptr_q     <= '0;
      fill_q       <= '0;
      start_q      <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      fifo_rd_q    <= fifo_rd_d;
      fifo_wr_q    <= fifo_wr_d;
      fifo_cnt_q   <= fifo_cnt_d;
      in_ready_q   <= in_ready_d;
      sample_q     <= sample_d;
      sample_out_q <= sample_out_d;
      oldest_q     <= oldest_d;
      wr_ptr_q     <= wr_ptr_d;
      fill_q       <= fill_d;
      start_q      <= start_d;
      overrun_q    <= overrun_d;
    end
  end

endmodule

// File: tb/tb_stft_sample_feeder.sv
// Bench for stft_sample_feeder at FFT_SIZE=8, FIFO_DEPTH=4, with a model STFT busy for 8 cycles after each pulse.
// Expected pulses come from a sample-history model that follows STFT_FEEDER_WARMUP_EN when it is defined.
module tb_stft_sample_feeder;
  localparam int W  = 16;
  localparam int N  = 8;
  localparam int FD = 4;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset_n, in_valid, in_ready, compute_busy, start_compute, overrun, clear_overrun;
  logic [W-1:0]  in_sample, sample_out, oldest_sample_out;
  logic [AW-1:0] wr_ptr;

  typedef struct {
    logic [W-1:0]  s;
    logic [W-1:0]  o;
    logic [AW-1:0] p;
    int            cyc;
  } pulse_t;

  pulse_t       seen_q[$];
  pulse_t       exp_q[$];
  logic [W-1:0] acc_q[$];
  int           cyc = 0;
  int           acc_cyc = 0;
  int           busy_cnt;
  int           checks = 0;
  int           failures = 0;
  int           push_timeouts = 0;
  bit           drop_seen;

  always #5 clk = ~clk;

  stft_sample_feeder #(.WORD_WIDTH(W), .FFT_SIZE(N), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .in_sample(in_sample),
    .compute_busy(compute_busy), .start_compute(start_compute), .sample_out(sample_out),
    .oldest_sample_out(oldest_sample_out), .wr_ptr(wr_ptr), .overrun(overrun), .clear_overrun(clear_overrun)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Model STFT: busy in cycles N+1..N+8 after a pulse in cycle N.
  always @(posedge clk or negedge reset_n)
    if (!reset_n) busy_cnt <= 0;
    else if (start_compute) busy_cnt <= N;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  assign compute_busy = (busy_cnt != 0);

  always @(negedge clk)
    if (reset_n && start_compute) seen_q.push_back('{sample_out, oldest_sample_out, wr_ptr, cyc});

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Expected pulse list from the history of accepted samples since reset.
  function automatic void build_expected();
    exp_q.delete();
    for (int k = 0; k < acc_q.size(); k++) begin
`ifdef STFT_FEEDER_WARMUP_EN
      exp_q.push_back('{acc_q[k], (k >= N) ? acc_q[k-N] : W'(0), AW'(k % N), 0});
`else
      if (k >= N) exp_q.push_back('{acc_q[k], acc_q[k-N], AW'(k % N), 0});
`endif
    end
  endfunction

  task automatic do_reset();
    in_valid = 1'b0; in_sample = '0; clear_overrun = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    acc_q.delete(); seen_q.delete(); drop_seen = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  // One cycle of stimulus, starting and ending at a falling edge.
  task automatic drive(input logic v, input logic [W-1:0] s, input logic clr);
    logic rdy;
    in_valid = v; in_sample = s; clear_overrun = clr;
    rdy = in_ready;
    @(posedge clk);
    @(negedge clk);
    if (v && rdy) begin acc_q.push_back(s); acc_cyc = cyc; end
    if (v && !rdy) drop_seen = 1'b1;
    in_valid = 1'b0; clear_overrun = 1'b0;
  endtask

  task automatic push(input logic [W-1:0] s);
    for (int t = 0; t < 400; t++) begin
      if (in_ready) begin drive(1'b1, s, 1'b0); return; end
      @(negedge clk);
    end
    push_timeouts++;
  endtask

  task automatic wait_pulses(input int n, input int settle, output bit to);
    int t = 0;
    in_valid = 1'b0; clear_overrun = 1'b0;
    while (seen_q.size() < n && t < 3000) begin @(negedge clk); t++; end
    to = (seen_q.size() < n);
    repeat (settle) @(negedge clk);
  endtask

  task automatic test_reset();
    in_valid = 1'b0; in_sample = '0; clear_overrun = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready: got %b exp 1", in_ready); end
    checks++; if (start_compute !== 1'b0) begin failures++; $display("FAIL rst_start: got %b exp 0", start_compute); end
    checks++; if (sample_out !== '0) begin failures++; $display("FAIL rst_sample_out: got %0h exp 0", sample_out); end
    checks++; if (oldest_sample_out !== '0) begin failures++; $display("FAIL rst_oldest: got %0h exp 0", oldest_sample_out); end
    checks++; if (wr_ptr !== '0) begin failures++; $display("FAIL rst_wr_ptr: got %0d exp 0", wr_ptr); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL rst_overrun: got %b exp 0", overrun); end
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (in_ready !== 1'b1 || start_compute !== 1'b0 || wr_ptr !== '0) begin
      failures++; $display("FAIL rst_idle: ready=%b start=%b wr_ptr=%0d exp 1/0/0", in_ready, start_compute, wr_ptr);
    end
  endtask

  task automatic test_single();
    bit to;
    do_reset();
    push(W'(100));
    build_expected();
    wait_pulses(exp_q.size(), 40, to);
    checks++; if (to || seen_q.size() != exp_q.size()) begin
      failures++; $display("FAIL single_count: got %0d pulses exp %0d", seen_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < seen_q.size()) begin
      checks++;
      if (seen_q[i].s !== exp_q[i].s || seen_q[i].o !== exp_q[i].o || seen_q[i].p !== exp_q[i].p) begin
        failures++; $display("FAIL single_pulse: got s=%0d o=%0d p=%0d exp s=%0d o=%0d p=%0d",
                             seen_q[i].s, seen_q[i].o, seen_q[i].p, exp_q[i].s, exp_q[i].o, exp_q[i].p);
      end
    end
`ifdef STFT_FEEDER_WARMUP_EN
    checks++; if (seen_q.size() == 0 || seen_q[0].cyc != acc_cyc + 2) begin
      failures++; $display("FAIL single_latency: got pulse cycle %0d exp %0d", (seen_q.size() == 0) ? -1 : seen_q[0].cyc, acc_cyc + 2);
    end
`endif
    checks++; if (wr_ptr !== AW'(1)) begin failures++; $display("FAIL single_wr_ptr: got %0d exp 1", wr_ptr); end
  endtask

  task automatic test_wrap();
    bit to;
    do_reset();
    for (int v = 1; v <= 10; v++) push(W'(v));
    build_expected();
    wait_pulses(exp_q.size(), 80, to);
    checks++; if (to || seen_q.size() != exp_q.size()) begin
      failures++; $display("FAIL wrap_count: got %0d pulses exp %0d", seen_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < seen_q.size()) begin
      checks++;
      if (seen_q[i].s !== exp_q[i].s || seen_q[i].o !== exp_q[i].o || seen_q[i].p !== exp_q[i].p) begin
        failures++; $display("FAIL wrap_pulse%0d: got s=%0d o=%0d p=%0d exp s=%0d o=%0d p=%0d", i,
                             seen_q[i].s, seen_q[i].o, seen_q[i].p, exp_q[i].s, exp_q[i].o, exp_q[i].p);
      end
    end
    for (int i = 1; i < seen_q.size(); i++) begin
      checks++; if (seen_q[i].cyc - seen_q[i-1].cyc < N + 3) begin
        failures++; $display("FAIL wrap_gap%0d: got %0d cycles exp >= %0d", i, seen_q[i].cyc - seen_q[i-1].cyc, N + 3);
      end
    end
    checks++; if (wr_ptr !== AW'(10 % N)) begin failures++; $display("FAIL wrap_wr_ptr: got %0d exp %0d", wr_ptr, 10 % N); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL wrap_overrun: got %b exp 0", overrun); end
  endtask

  task automatic test_overrun();
    bit to;
    do_reset();
    for (int k = 0; k < 5; k++) drive(1'b1, W'(10 + k), 1'b0);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL ovr_full_ready: got %b exp 0", in_ready); end
    checks++; if (acc_q.size() != 5) begin failures++; $display("FAIL ovr_accepted: got %0d exp 5", acc_q.size()); end
    drive(1'b1, W'(15), 1'b0);
    checks++; if (overrun !== 1'b1 || in_ready !== 1'b0) begin
      failures++; $display("FAIL ovr_drop: got overrun=%b ready=%b exp 1/0", overrun, in_ready);
    end
    drive(1'b1, W'(16), 1'b1);
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_set_wins: got %b exp 1", overrun); end
`ifndef STFT_FEEDER_WARMUP_EN
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL ovr_ready_after_pop: got %b exp 1", in_ready); end
`endif
    drive(1'b0, '0, 1'b1);
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_clear: got %b exp 0", overrun); end
    build_expected();
    wait_pulses(exp_q.size(), 80, to);
    checks++; if (to || seen_q.size() != exp_q.size()) begin
      failures++; $display("FAIL ovr_count: got %0d pulses exp %0d", seen_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < seen_q.size()) begin
      checks++;
      if (seen_q[i].s !== exp_q[i].s || seen_q[i].o !== exp_q[i].o || seen_q[i].p !== exp_q[i].p) begin
        failures++; $display("FAIL ovr_pulse%0d: got s=%0d o=%0d p=%0d exp s=%0d o=%0d p=%0d", i,
                             seen_q[i].s, seen_q[i].o, seen_q[i].p, exp_q[i].s, exp_q[i].o, exp_q[i].p);
      end
    end
    checks++; if (wr_ptr !== AW'(5)) begin failures++; $display("FAIL ovr_wr_ptr: got %0d exp 5", wr_ptr); end
  endtask

  task automatic test_mid_reset();
    bit to;
    int t = 0;
    int hits = 0;
    do_reset();
    for (int i = 0; i <= N; i++) push(W'(16'h1000 + i));
    build_expected();
    while (seen_q.size() < exp_q.size() && t < 3000) begin @(negedge clk); t++; end
    checks++; if (seen_q.size() < exp_q.size()) begin
      failures++; $display("FAIL midrst_pre_pulses: got %0d exp %0d", seen_q.size(), exp_q.size());
    end
    drive(1'b1, W'(16'h2000), 1'b0);
    drive(1'b1, W'(16'h2001), 1'b0);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++; if (start_compute !== 1'b0 || wr_ptr !== '0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL midrst_clear: got start=%b wr_ptr=%0d ready=%b exp 0/0/1", start_compute, wr_ptr, in_ready);
    end
    repeat (2) @(negedge clk);
    acc_q.delete(); seen_q.delete();
    reset_n = 1'b1;
    repeat (30) begin @(negedge clk); if (start_compute) hits++; end
    checks++; if (hits != 0 || wr_ptr !== '0) begin
      failures++; $display("FAIL midrst_quiet: got %0d pulses wr_ptr=%0d exp 0/0", hits, wr_ptr);
    end
    push(W'(5));
    build_expected();
    wait_pulses(exp_q.size(), 40, to);
    checks++; if (to || seen_q.size() != exp_q.size()) begin
      failures++; $display("FAIL midrst_count: got %0d pulses exp %0d", seen_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < seen_q.size()) begin
      checks++;
      if (seen_q[i].s !== exp_q[i].s || seen_q[i].o !== exp_q[i].o || seen_q[i].p !== exp_q[i].p) begin
        failures++; $display("FAIL midrst_pulse: got s=%0d o=%0d p=%0d exp s=%0d o=%0d p=%0d",
                             seen_q[i].s, seen_q[i].o, seen_q[i].p, exp_q[i].s, exp_q[i].o, exp_q[i].p);
      end
    end
    checks++; if (wr_ptr !== AW'(1)) begin failures++; $display("FAIL midrst_wr_ptr: got %0d exp 1", wr_ptr); end
  endtask

  task automatic test_random();
    bit to;
    do_reset();
    for (int c = 0; c < 90; c++) drive(($urandom_range(0, 1) == 0), W'($urandom), 1'b0);
    build_expected();
    wait_pulses(exp_q.size(), 80, to);
    checks++; if (to || seen_q.size() != exp_q.size()) begin
      failures++; $display("FAIL rand_count: got %0d pulses exp %0d", seen_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < seen_q.size()) begin
      checks++;
      if (seen_q[i].s !== exp_q[i].s || seen_q[i].o !== exp_q[i].o || seen_q[i].p !== exp_q[i].p) begin
        failures++; $display("FAIL rand_pulse%0d: got s=%0h o=%0h p=%0d exp s=%0h o=%0h p=%0d", i,
                             seen_q[i].s, seen_q[i].o, seen_q[i].p, exp_q[i].s, exp_q[i].o, exp_q[i].p);
      end
    end
    for (int i = 1; i < seen_q.size(); i++) begin
      checks++; if (seen_q[i].cyc - seen_q[i-1].cyc < N + 3) begin
        failures++; $display("FAIL rand_gap%0d: got %0d cycles exp >= %0d", i, seen_q[i].cyc - seen_q[i-1].cyc, N + 3);
      end
    end
    checks++; if (wr_ptr !== AW'(acc_q.size() % N)) begin
      failures++; $display("FAIL rand_wr_ptr: got %0d exp %0d", wr_ptr, acc_q.size() % N);
    end
    checks++; if (overrun !== drop_seen) begin failures++; $display("FAIL rand_overrun: got %b exp %b", overrun, drop_seen); end
    checks++; if (push_timeouts != 0) begin failures++; $display("FAIL push_timeout: got %0d exp 0", push_timeouts); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_overrun();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
